// File: rtl/msg_seq_pkg.sv
// Shared types and width helpers for the multi-channel message frame sequencer.
package msg_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam int unsigned FRAME_CNT_W = 16;

  // Bits needed to index 0..n-1 (never less than 1).
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Bits needed to hold the value n itself (never less than 1).
  function automatic int unsigned val_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/msg_code_phase_add.sv
// Per-channel chip address: (chip + offset) mod PCODE_LEN, registered; forced to 0 when not enabled.
module msg_code_phase_add
  #(parameter int unsigned PCODE_LEN = 40920,
    parameter int unsigned AW        = 16)
  (input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic [AW-1:0] chip,
   input  logic [AW-1:0] off,
   output logic [AW-1:0] addr_o);

  localparam logic [AW:0] LEN_S = PCODE_LEN[AW:0];

  logic [AW:0]   sum;
  logic [AW:0]   wrapped;
  logic [AW-1:0] addr_d;
  logic [AW-1:0] addr_q;

  // Both operands are below PCODE_LEN, so one conditional subtract suffices.
  always_comb begin
    sum     = {1'b0, chip} + {1'b0, off};
    wrapped = (sum >= LEN_S) ? (sum - LEN_S) : sum;
    addr_d  = en ? wrapped[AW-1:0] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) addr_q <= '0;
    else      addr_q <= addr_d;
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/msg_frame_sequencer.sv
// Multi-channel P-code/message addressing with frame accounting, burst mode and PPS stretcher.
// Optional: MSG_SEQ_PPS_RESYNC_EN makes sys_pps in RUN realign the counters and flag sync_err.
module msg_frame_sequencer
  import msg_seq_pkg::*;
  #(parameter int unsigned PCODE_LEN     = 40920,
    parameter int unsigned PCODE_REPEATS = 10,
    parameter int unsigned MESSAGE_LEN   = 120,
    parameter int unsigned NUM_CH        = 4,
    parameter int unsigned PPS_WIDTH     = 4092000,
    localparam int unsigned AW = idx_width(PCODE_LEN),
    localparam int unsigned MW = idx_width(MESSAGE_LEN))
  (input  logic                   clk,
   input  logic                   rst,
   input  logic                   sys_time_sync_done,
   input  logic                   sys_pps,
   input  logic                   dac_valid,
   input  logic                   ch_offset_wr,
   input  logic [NUM_CH*AW-1:0]   ch_code_offset,
   input  logic                   burst_mode,
   input  logic [7:0]             burst_frames,
   output logic [NUM_CH*AW-1:0]   pcode_addr_o,
   output logic [MW-1:0]          msg_addr_o,
   output logic                   frame_start,
   output logic [FRAME_CNT_W-1:0] frame_count,
   output logic                   busy,
   output logic                   cfg_err,
   output logic                   sync_err,
   output logic                   pps_out);

  localparam int unsigned RW = idx_width(PCODE_REPEATS);
  localparam int unsigned PW = val_width(PPS_WIDTH);
  localparam logic [AW-1:0] CHIP_LAST = AW'(PCODE_LEN - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(PCODE_REPEATS - 1);
  localparam logic [MW-1:0] BIT_LAST  = MW'(MESSAGE_LEN - 1);

  seq_state_e             state_q, state_d;
  logic [AW-1:0]          chip_q, chip_d;
  logic [RW-1:0]          rep_q, rep_d;
  logic [MW-1:0]          bit_q, bit_d;
  logic [FRAME_CNT_W-1:0] fc_q, fc_d;
  logic                   fs_q, fs_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   sync_err_q, sync_err_d;
  logic [PW-1:0]          pps_cnt_q, pps_cnt_d;
  logic [NUM_CH*AW-1:0]   shadow_q, shadow_d;
  logic [NUM_CH*AW-1:0]   act_q, act_d;
  logic [MW-1:0]          msg_addr_q, msg_addr_d;
  logic [FRAME_CNT_W-1:0] burst_max;
  logic                   offset_bad;

  always_comb begin
    state_d    = state_q;
    chip_d     = chip_q;
    rep_d      = rep_q;
    bit_d      = bit_q;
    fc_d       = fc_q;
    fs_d       = 1'b0;
    cfg_err_d  = 1'b0;
    sync_err_d = 1'b0;
    pps_cnt_d  = pps_cnt_q;
    shadow_d   = shadow_q;
    act_d      = act_q;
    msg_addr_d = (state_q == ST_RUN) ? bit_q : '0;
    burst_max  = (burst_frames == 8'd0) ? FRAME_CNT_W'(1) : FRAME_CNT_W'(burst_frames);

    offset_bad = 1'b0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (32'(ch_code_offset[k*AW +: AW]) >= PCODE_LEN) offset_bad = 1'b1;
    end
    if (ch_offset_wr) begin
      if (offset_bad) cfg_err_d = 1'b1;
      else            shadow_d  = ch_code_offset;
    end

    if (sys_pps && (state_q != ST_IDLE)) pps_cnt_d = PW'(PPS_WIDTH);
    else if (pps_cnt_q != '0)            pps_cnt_d = pps_cnt_q - PW'(1);

    if (!sys_time_sync_done) begin
      state_d = ST_IDLE;
      chip_d  = '0;
      rep_d   = '0;
      bit_d   = '0;
      fc_d    = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_ARM;
        ST_ARM, ST_DONE: begin
          if (sys_pps) begin
            state_d = ST_RUN;
            chip_d  = '0;
            rep_d   = '0;
            bit_d   = '0;
            fc_d    = '0;
            act_d   = shadow_q;
          end
        end
        ST_RUN: begin
`ifdef MSG_SEQ_PPS_RESYNC_EN
          if (sys_pps) begin
            sync_err_d = (chip_q != '0) || (rep_q != '0) || (bit_q != '0);
            chip_d     = '0;
            rep_d      = '0;
            bit_d      = '0;
          end else
`endif
          if (dac_valid) begin
            if (chip_q != CHIP_LAST) chip_d = chip_q + AW'(1);
            else begin
              chip_d = '0;
              if (rep_q != REP_LAST) rep_d = rep_q + RW'(1);
              else begin
                rep_d = '0;
                if (bit_q != BIT_LAST) bit_d = bit_q + MW'(1);
                else begin
                  bit_d = '0;
                  fs_d  = 1'b1;
                  fc_d  = fc_q + FRAME_CNT_W'(1);
                  act_d = shadow_q;
                  if (burst_mode && ((fc_q + FRAME_CNT_W'(1)) == burst_max)) state_d = ST_DONE;
                end
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      chip_q     <= '0;
      rep_q      <= '0;
      bit_q      <= '0;
      fc_q       <= '0;
      fs_q       <= 1'b0;
      cfg_err_q  <= 1'b0;
      sync_err_q <= 1'b0;
      pps_cnt_q  <= '0;
      shadow_q   <= '0;
      act_q      <= '0;
      msg_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      chip_q     <= chip_d;
      rep_q      <= rep_d;
      bit_q      <= bit_d;
      fc_q       <= fc_d;
      fs_q       <= fs_d;
      cfg_err_q  <= cfg_err_d;
      sync_err_q <= sync_err_d;
      pps_cnt_q  <= pps_cnt_d;
      shadow_q   <= shadow_d;
      act_q      <= act_d;
      msg_addr_q <= msg_addr_d;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    msg_code_phase_add #(.PCODE_LEN(PCODE_LEN), .AW(AW)) u_add (
      .clk    (clk),
      .rst    (rst),
      .en     (state_q == ST_RUN),
      .chip   (chip_q),
      .off    (act_q[k*AW +: AW]),
      .addr_o (pcode_addr_o[k*AW +: AW])
    );
  end

  assign msg_addr_o  = msg_addr_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;
  assign busy        = (state_q == ST_RUN);
  assign cfg_err     = cfg_err_q;
  assign sync_err    = sync_err_q;
  assign pps_out     = (pps_cnt_q != '0);

endmodule

// File: tb/tb_msg_frame_sequencer.sv
// Self-checking bench for msg_frame_sequencer against a chip-count reference model.
module tb_msg_frame_sequencer;

  localparam int unsigned L   = 8;
  localparam int unsigned R   = 2;
  localparam int unsigned M   = 3;
  localparam int unsigned NCH = 2;
  localparam int unsigned PW  = 5;
  localparam int unsigned LRM = L * R * M;
`ifdef MSG_SEQ_PPS_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, sd, pps, dv, wr, bm;
  logic [5:0]  offs;
  logic [7:0]  bf;
  logic [5:0]  pa;
  logic [1:0]  ma;
  logic        fs, busy, cfg, serr, ppso;
  logic [15:0] fc;
  logic [5:0]  pa2;
  logic [1:0]  ma2;
  logic        fs2, busy2, cfg2, serr2, ppso2;
  logic [15:0] fc2;
  logic [28:0] got;

  always #5 clk = ~clk;
  assign got = {pa, ma, fs, fc, busy, cfg, serr, ppso};

  msg_frame_sequencer #(.PCODE_LEN(L), .PCODE_REPEATS(R), .MESSAGE_LEN(M), .NUM_CH(NCH), .PPS_WIDTH(PW)) u_dut (
    .clk(clk), .rst(rst), .sys_time_sync_done(sd), .sys_pps(pps), .dac_valid(dv),
    .ch_offset_wr(wr), .ch_code_offset(offs), .burst_mode(bm), .burst_frames(bf),
    .pcode_addr_o(pa), .msg_addr_o(ma), .frame_start(fs), .frame_count(fc),
    .busy(busy), .cfg_err(cfg), .sync_err(serr), .pps_out(ppso));

  // Second instance with a non-power-of-two code length so out-of-range offsets are expressible.
  msg_frame_sequencer #(.PCODE_LEN(6), .PCODE_REPEATS(R), .MESSAGE_LEN(M), .NUM_CH(NCH), .PPS_WIDTH(PW)) u_dut6 (
    .clk(clk), .rst(rst), .sys_time_sync_done(sd), .sys_pps(pps), .dac_valid(dv),
    .ch_offset_wr(wr), .ch_code_offset(offs), .burst_mode(bm), .burst_frames(bf),
    .pcode_addr_o(pa2), .msg_addr_o(ma2), .frame_start(fs2), .frame_count(fc2),
    .busy(busy2), .cfg_err(cfg2), .sync_err(serr2), .pps_out(ppso2));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: 0 idle, 1 armed, 2 running, 3 burst done; n = chips since last realign.
  int m_state, n, m_fc, pcnt, e_ma;
  int sh [NCH];
  int act[NCH];
  int e_pa[NCH];
  bit e_fs, e_cfg, e_serr;

  function automatic logic [28:0] exp_vec();
    return {3'(e_pa[1]), 3'(e_pa[0]), 2'(e_ma), e_fs, 16'(m_fc), (m_state == 2), e_cfg, e_serr, (pcnt > 0)};
  endfunction

  task automatic model_reset();
    m_state = 0; n = 0; m_fc = 0; pcnt = 0; e_ma = 0;
    e_fs = 0; e_cfg = 0; e_serr = 0;
    for (int k = 0; k < NCH; k++) begin sh[k] = 0; act[k] = 0; e_pa[k] = 0; end
  endtask

  task automatic model_update();
    int  old;
    int  bmax;
    bit  rej;
    logic [5:0] o;
    old = m_state;
    o = offs;
    e_fs = 0; e_cfg = 0; e_serr = 0;
    for (int k = 0; k < NCH; k++) e_pa[k] = (old == 2) ? ((n % L) + act[k]) % L : 0;
    e_ma = (old == 2) ? (n / (L * R)) % M : 0;
    if (pps && old != 0) pcnt = PW;
    else if (pcnt > 0)   pcnt = pcnt - 1;
    if (!sd) begin
      m_state = 0; n = 0; m_fc = 0;
    end else begin
      case (old)
        0: m_state = 1;
        1, 3: if (pps) begin
          m_state = 2; n = 0; m_fc = 0;
          for (int k = 0; k < NCH; k++) act[k] = sh[k];
        end
        default: begin
          if (pps && RESYNC) begin
            e_serr = ((n % LRM) != 0);
            n = 0;
          end else if (dv) begin
            n = n + 1;
            if (n % LRM == 0) begin
              e_fs = 1;
              m_fc = (m_fc + 1) % 65536;
              for (int k = 0; k < NCH; k++) act[k] = sh[k];
              bmax = (bf == 0) ? 1 : int'(bf);
              if (bm && m_fc == bmax) begin m_state = 3; n = 0; end
            end
          end
        end
      endcase
    end
    if (wr) begin
      rej = 0;
      for (int k = 0; k < NCH; k++) if (int'(o[k*3 +: 3]) >= L) rej = 1;
      if (rej) e_cfg = 1;
      else for (int k = 0; k < NCH; k++) sh[k] = int'(o[k*3 +: 3]);
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b0; sd = 0; pps = 0; dv = 0; wr = 0; bm = 0; offs = '0; bf = '0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    total++;
    if (got !== 29'd0) begin bad++; $display("FAIL reset_outputs got=%h want=0", got); end
    total++;
    if (pa2 !== 6'd0) begin bad++; $display("FAIL reset_pa2 got=%h want=0", pa2); end
    rst = 1'b1;
  endtask

  task automatic test_basic();
    sd = 1; tick();
    total++;
    if (got !== exp_vec()) begin bad++; $display("FAIL basic_arm cyc=%0d got=%h want=%h", cyc, got, exp_vec()); end
    pps = 1; tick(); pps = 0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b want=1", busy); end
    dv = 1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL basic cyc=%0d got=%h want=%h", cyc, got, exp_vec()); end
      if (i == 8)  begin total++; if (pa[2:0] !== 3'd7) begin bad++; $display("FAIL basic_ch0_last got=%0d want=7", pa[2:0]); end end
      if (i == 9)  begin total++; if (pa[2:0] !== 3'd0) begin bad++; $display("FAIL basic_ch0_wrap got=%0d want=0", pa[2:0]); end end
      if (i == 17) begin total++; if (ma !== 2'd1) begin bad++; $display("FAIL basic_msg1 got=%0d want=1", ma); end end
      if (i == 48) begin total++; if ({fs, fc} !== {1'b1, 16'd1}) begin bad++; $display("FAIL basic_frame fs=%b fc=%0d want fs=1 fc=1", fs, fc); end end
    end
    dv = 0;
  endtask

  task automatic test_offset();
    sd = 0; tick(); sd = 1;
    wr = 1; offs = {3'd5, 3'd0}; tick(); wr = 0;
    pps = 1; tick(); pps = 0; dv = 1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL offset cyc=%0d got=%h want=%h", cyc, got, exp_vec()); end
      if (i == 1) begin total++; if (pa[5:3] !== 3'd5) begin bad++; $display("FAIL offset_first got=%0d want=5", pa[5:3]); end end
      if (i == 4) begin total++; if (pa[5:3] !== 3'd0) begin bad++; $display("FAIL offset_wrap got=%0d want=0", pa[5:3]); end end
    end
    dv = 0;
  endtask

  task automatic test_cfg_reject();
    sd = 0; tick(); sd = 1;
    wr = 1; offs = {3'd5, 3'd0}; tick();
    offs = {3'd7, 3'd0}; tick(); wr = 0;
    total++;
    if (cfg2 !== 1'b1) begin bad++; $display("FAIL cfg_err_pulse got=%b want=1", cfg2); end
    total++;
    if (got !== exp_vec()) begin bad++; $display("FAIL cfg_main cyc=%0d got=%h want=%h", cyc, got, exp_vec()); end
    pps = 1; tick(); pps = 0;
    total++;
    if (cfg2 !== 1'b0) begin bad++; $display("FAIL cfg_err_single got=%b want=0", cfg2); end
    dv = 1; tick();
    total++;
    if (pa2[5:3] !== 3'd5) begin bad++; $display("FAIL cfg_keep_shadow got=%0d want=5", pa2[5:3]); end
    total++;
    if (pa[5:3] !== 3'd7) begin bad++; $display("FAIL cfg_accept_last got=%0d want=7", pa[5:3]); end
  endtask

  task automatic test_midframe();
    dv = 1;
    for (int i = 0; i < 80; i++) begin
      if (i == 10) begin wr = 1; offs = 6'($urandom); end
      else wr = 0;
      tick();
      total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL midframe cyc=%0d got=%h want=%h", cyc, got, exp_vec()); end
    end
    wr = 0; dv = 0;
  endtask

  task automatic test_burst();
    int frames;
    for (int b = 0; b < 2; b++) begin
      bf = (b == 0) ? 8'd2 : 8'd0;
      frames = (b == 0) ? 2 : 1;
      sd = 0; tick(); sd = 1; tick();
      bm = 1; pps = 1; tick(); pps = 0; dv = 1;
      for (int i = 0; i < frames * 48 + 2; i++) begin
        tick();
        total++;
        if (got !== exp_vec()) begin bad++; $display("FAIL burst cyc=%0d got=%h want=%h", cyc, got, exp_vec()); end
      end
      total++;
      if ({busy, pa, ma} !== 9'd0) begin bad++; $display("FAIL burst_done busy=%b pa=%h ma=%0d want 0", busy, pa, ma); end
      total++;
      if (fc !== 16'(frames)) begin bad++; $display("FAIL burst_count got=%0d want=%0d", fc, frames); end
      pps = 1; tick(); pps = 0;
      total++;
      if ({busy, fc} !== {1'b1, 16'd0}) begin bad++; $display("FAIL burst_rearm busy=%b fc=%0d want busy=1 fc=0", busy, fc); end
    end
    bm = 0; dv = 0;
  endtask

  task automatic test_pps();
    int high;
    dv = 0;
    for (int i = 0; i < 6; i++) tick();
    high = 0;
    pps = 1; tick(); pps = 0;
    if (ppso) high++;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ppso) high++;
      total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL pps cyc=%0d got=%h want=%h", cyc, got, exp_vec()); end
    end
    total++;
    if (high != 5) begin bad++; $display("FAIL pps_width got=%0d want=5", high); end
    high = 0;
    pps = 1; tick(); pps = 0; if (ppso) high++;
    tick(); if (ppso) high++;
    tick(); if (ppso) high++;
    pps = 1; tick(); pps = 0; if (ppso) high++;
    for (int i = 0; i < 10; i++) begin tick(); if (ppso) high++; end
    total++;
    if (high != 8) begin bad++; $display("FAIL pps_restart got=%0d want=8", high); end
  endtask

  task automatic test_resync();
    sd = 0; tick(); sd = 1; tick();
    pps = 1; tick(); pps = 0; dv = 1;
    tick(); tick(); tick();
    pps = 1; tick(); pps = 0;
    total++;
    if (serr !== RESYNC) begin bad++; $display("FAIL resync_err got=%b want=%b", serr, RESYNC); end
    for (int i = 0; i < 8; i++) begin
      tick();
      total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL resync cyc=%0d got=%h want=%h", cyc, got, exp_vec()); end
    end
    dv = 0;
  endtask

  task automatic test_random();
    bm = 1'($urandom);
    bf = 8'($urandom_range(0, 3));
    for (int i = 0; i < 600; i++) begin
      sd   = ($urandom_range(0, 63) != 0);
      pps  = ($urandom_range(0, 29) == 0);
      dv   = ($urandom_range(0, 3) != 0);
      wr   = ($urandom_range(0, 9) == 0);
      offs = 6'($urandom);
      tick();
      total++;
      if (got !== exp_vec()) begin bad++; $display("FAIL random cyc=%0d got=%h want=%h", cyc, got, exp_vec()); end
    end
    sd = 1; pps = 0; dv = 0; wr = 0; bm = 0;
  endtask

  task automatic test_async_reset();
    sd = 0; tick(); sd = 1; tick();
    pps = 1; tick(); pps = 0; dv = 1;
    for (int i = 0; i < 20; i++) tick();
    #3 rst = 1'b0;
    #1;
    total++;
    if (got !== 29'd0) begin bad++; $display("FAIL async_reset got=%h want=0", got); end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1; dv = 0;
    tick();
    total++;
    if (got !== exp_vec()) begin bad++; $display("FAIL after_reset cyc=%0d got=%h want=%h", cyc, got, exp_vec()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_offset();
    test_cfg_reject();
    test_midframe();
    test_burst();
    test_pps();
    test_resync();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
